// File: rtl/airi5c_pcpi_arbiter.sv
// Shares one PCPI port between N_CP self-decoding coprocessors. Index 0 has the
// highest priority. Responses are registered, and a watchdog force-completes hung units.
module airi5c_pcpi_arbiter #(
  parameter int N_CP    = 2,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 pcpi_valid,
  input  logic [31:0]          pcpi_insn,
  input  logic [31:0]          pcpi_rs1,
  input  logic [31:0]          pcpi_rs2,
  input  logic [31:0]          pcpi_rs3,
  output logic                 pcpi_wr,
  output logic [31:0]          pcpi_rd,
  output logic [31:0]          pcpi_rd2,
  output logic                 pcpi_use_rd64,
  output logic                 pcpi_wait,
  output logic                 pcpi_ready,
  output logic [N_CP-1:0]      cp_valid,
  output logic [31:0]          cp_insn,
  output logic [31:0]          cp_rs1,
  output logic [31:0]          cp_rs2,
  output logic [31:0]          cp_rs3,
  input  logic [N_CP-1:0]      cp_wr,
  input  logic [32*N_CP-1:0]   cp_rd,
  input  logic [32*N_CP-1:0]   cp_rd2,
  input  logic [N_CP-1:0]      cp_use_rd64,
  input  logic [N_CP-1:0]      cp_wait,
  input  logic [N_CP-1:0]      cp_ready,
  output logic [N_CP-1:0]      grant,
  output logic                 busy,
  output logic                 err_timeout,
  input  logic                 err_clr
);

  localparam int IDX_W = (N_CP > 1) ? $clog2(N_CP) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit WD_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             cap_wr;
  logic             cap_use_rd64;
  logic [31:0]      cap_rd;
  logic [31:0]      cap_rd2;

  logic [N_CP-1:0]  claim;
  logic [N_CP-1:0]  sel_oh;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_ready;
  logic             cur_wr;
  logic             cur_use_rd64;
  logic [31:0]      cur_rd;
  logic [31:0]      cur_rd2;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_CP-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_CP - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  assign cp_insn = pcpi_insn;
  assign cp_rs1  = pcpi_rs1;
  assign cp_rs2  = pcpi_rs2;
  assign cp_rs3  = pcpi_rs3;

  assign claim   = cp_wait | cp_ready;
  assign sel_oh  = claim & ~(claim - N_CP'(1));
  assign sel_idx = lowest_idx(claim);
  assign gnt_idx = lowest_idx(grant);

  // In IDLE the candidate is the winning claimant; afterwards it is the current owner.
  assign cur_idx      = (state == IDLE) ? sel_idx : gnt_idx;
  assign cur_ready    = cp_ready[cur_idx];
  assign cur_wr       = cp_wr[cur_idx];
  assign cur_use_rd64 = cp_use_rd64[cur_idx];
  assign cur_rd       = cp_rd[32*cur_idx +: 32];
  assign cur_rd2      = cp_rd2[32*cur_idx +: 32];

  assign busy          = (state != IDLE);
  assign pcpi_ready    = (state == RESP);
  assign pcpi_wr       = (state == RESP) & cap_wr;
  assign pcpi_use_rd64 = (state == RESP) & cap_use_rd64;
  assign pcpi_rd       = (state == RESP) ? cap_rd  : 32'd0;
  assign pcpi_rd2      = (state == RESP) ? cap_rd2 : 32'd0;

  // Gated by nreset so the request-side outputs also drop the moment reset asserts.
  always_comb begin
    cp_valid  = '0;
    pcpi_wait = 1'b0;
    if (nreset) begin
      case (state)
        IDLE: begin
          cp_valid  = {N_CP{pcpi_valid}};
          pcpi_wait = pcpi_valid & (|claim);
        end
        BUSY: begin
          cp_valid  = grant & {N_CP{pcpi_valid}};
          pcpi_wait = 1'b1;
        end
        default: begin
          cp_valid  = '0;
          pcpi_wait = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state        <= IDLE;
      grant        <= '0;
      counter      <= '0;
      cap_wr       <= 1'b0;
      cap_use_rd64 <= 1'b0;
      cap_rd       <= 32'd0;
      cap_rd2      <= 32'd0;
      err_timeout  <= 1'b0;
    end else begin
      // A watchdog set later in this block overrides a same-cycle clear.
      if (err_clr) err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pcpi_valid && (|claim)) begin
            grant <= sel_oh;
            if (cur_ready) begin
              cap_wr       <= cur_wr;
              cap_use_rd64 <= cur_use_rd64;
              cap_rd       <= cur_rd;
              cap_rd2      <= cur_rd2;
              state        <= RESP;
            end else begin
              counter <= '0;
              state   <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!pcpi_valid) begin
            grant <= '0;
            state <= IDLE;
          end else if (cur_ready) begin
            cap_wr       <= cur_wr;
            cap_use_rd64 <= cur_use_rd64;
            cap_rd       <= cur_rd;
            cap_rd2      <= cur_rd2;
            state        <= RESP;
          end else if (WD_EN && (counter == TO_LAST)) begin
            cap_wr       <= 1'b0;
            cap_use_rd64 <= 1'b0;
            cap_rd       <= 32'd0;
            cap_rd2      <= 32'd0;
            err_timeout  <= 1'b1;
            state        <= RESP;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        RESP: begin
          grant <= '0;
          state <= IDLE;
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!nreset) $onehot0(grant));
  a_ready_pulse:  assert property (@(posedge clk) disable iff (!nreset) pcpi_ready |=> !pcpi_ready);
  a_idle_nogrant: assert property (@(posedge clk) disable iff (!nreset) (state == IDLE) |-> (grant == '0));

endmodule

// File: doc/airi5c_pcpi_arbiter.md
Name: airi5c_pcpi_arbiter

Overview:
Shares the core's single PCPI port between N_CP coprocessors, for example the custom bit-reverse unit and the SIMD unit. Each coprocessor self-decodes and claims the instruction by asserting wait or ready. The arbiter grants exactly one claimant, sequences the transaction, and registers the response. It returns a one-cycle ready pulse to the core. A watchdog aborts hung coprocessors.

Parameters:
N_CP, 2, number of coprocessors; index 0 has highest priority.
TIMEOUT, 64, maximum BUSY cycles before forced completion; 0 disables the watchdog.
CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W >= TIMEOUT.

Ports:
clk  in  1  core clock
nreset  in  1  asynchronous active-low reset
pcpi_valid  in  1  core PCPI request
pcpi_insn  in  32  instruction
pcpi_rs1 / pcpi_rs2 / pcpi_rs3  in  32 each  operands
pcpi_wr  out  1  result write enable (core side)
pcpi_rd / pcpi_rd2  out  32 each  results
pcpi_use_rd64  out  1  second result valid
pcpi_wait  out  1  instruction claimed, core stalls
pcpi_ready  out  1  transaction complete
cp_valid  out  N_CP  per-coprocessor valid
cp_insn / cp_rs1 / cp_rs2 / cp_rs3  out  32 each  broadcast copies of the core inputs
cp_wr  in  N_CP  per-coprocessor write enable
cp_rd / cp_rd2  in  32*N_CP each  flattened results; slice i is [32*i+31:32*i]
cp_use_rd64 / cp_wait / cp_ready  in  N_CP each
grant  out  N_CP  one-hot current owner; 0 when idle
busy  out  1  state != IDLE
err_timeout  out  1  sticky watchdog flag
err_clr  in  1  clears err_timeout

Behaviour:
- States: IDLE, BUSY, RESP. Reset enters IDLE.
- Reset values: grant=0, pcpi_ready=0, pcpi_wr=0, pcpi_rd=0, pcpi_rd2=0, pcpi_use_rd64=0, pcpi_wait=0, err_timeout=0, counter=0, cp_valid=0.
- The cp_insn/rs buses are combinational copies of the core inputs in all states.
- IDLE:
  - cp_valid = {N_CP{pcpi_valid}}; claim = cp_wait | cp_ready.
  - pcpi_wait = pcpi_valid & |claim (combinational).
  - If pcpi_valid & |claim: grant <= lowest set index of claim.
    - If that cp's ready is set, capture wr/rd/rd2/use_rd64 and go to RESP.
    - Otherwise go to BUSY, counter <= 0.
  - No claimant: stay IDLE and drive nothing. The core's own illegal-instruction timeout handles this case.
- BUSY:
  - cp_valid = grant & {N_CP{pcpi_valid}}; non-granted units see valid low from the first BUSY cycle. pcpi_wait=1.
  - Granted cp_ready=1: capture that slice's wr/rd/rd2/use_rd64 and go to RESP.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: capture wr=0, rd=0, rd2=0, use_rd64=0; set err_timeout; go to RESP. Otherwise counter++.
  - If ready and timeout occur in the same cycle, ready wins and no error is set.
  - pcpi_valid low (core flush/trap): go to IDLE, grant <= 0, no ready, no error.
- RESP:
  - pcpi_ready=1 for exactly one cycle; pcpi_wr/rd/rd2/use_rd64 come from the capture registers; pcpi_wait=0; cp_valid=0.
  - Next state IDLE, grant <= 0.
  - Outside RESP, pcpi_wr=0 and pcpi_ready=0; pcpi_rd/rd2/use_rd64 read 0.
- Latency: coprocessor ready in cycle t gives pcpi_ready in cycle t+1.
- err_timeout: set has priority over err_clr in the same cycle.
- Back-to-back: a new pcpi_valid in the cycle after RESP is arbitrated normally.
- Asynchronous reset in any state returns all outputs to reset values immediately.

Test Plan:
1. Single unit: cp0 waits 3 cycles then ready with rd=0x0000_0001, wr=1 → one pcpi_ready pulse the next cycle; pcpi_rd=0x0000_0001, pcpi_wr=1, grant=01 during BUSY.
2. Dual claim: cp0 and cp1 both assert wait → grant=01; cp_valid[1]=0 from the first BUSY cycle; cp0 result 0xDEADBEEF is returned; cp1 output is ignored.
3. Zero-wait unit: cp1 asserts ready (rd=0x1234_5678, use_rd64=1, rd2=0xCAFE_F00D) together with valid → RESP the next cycle with all three values; no BUSY cycle occurs.
4. No claimant: valid held for 20 cycles, no wait/ready → pcpi_wait=0, busy=0, no ready pulse.
5. Watchdog, TIMEOUT=8: cp1 waits forever → pcpi_ready with pcpi_wr=0 after exactly 8 BUSY cycles; err_timeout=1 until err_clr is pulsed. Ready arriving on cycle 8 → normal completion, err_timeout=0.
6. Abort/reset: pcpi_valid drops mid-BUSY → IDLE with no ready, and the next instruction completes normally. nreset asserted mid-BUSY → all outputs 0 asynchronously.
